// File: rtl/axi4lite_arb2_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter: FSM states, response codes
// and packed views of the master-to-slave and slave-to-master signal groups.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_RESP,
        ST_FLUSH
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        bready;
        logic        arvalid;
        logic [31:0] araddr;
        logic        rready;
    } axil_req_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } axil_rsp_t;

endpackage

// File: rtl/axi4lite_arb2_if.sv
// AXI4-Lite bus bundle; "master" drives requests, "slave" drives responses.
interface axil_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_arb2_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that did not win last time.
module axil_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);
    always_comb begin
        if (req_i == 2'b11) grant_o = last_grant_i ? 2'b01 : 2'b10;
        else                grant_o = req_i;
    end
endmodule

// File: rtl/axi4lite_arb2.sv
// Single-outstanding 2:1 AXI4-Lite arbiter (CPU on inport0, debug on inport1).
// Optional slave watchdog with SLVERR reply and FLUSH state: AXIL_ARB_TIMEOUT_EN.
module axi4lite_arb2
    import axil_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    axil_if.slave      inport0,
    axil_if.slave      inport1,
    axil_if.master     outport,
    output logic [1:0] grant_o,
    output logic       timeout_o
);
    arb_state_e state_q;
    logic [1:0] grant_q;
    logic       last_grant_q;
    logic       aw_done_q, w_done_q;

    axil_req_t  req0, req1, req_sel, req_out;
    axil_rsp_t  rsp_slv, rsp_m, rsp0, rsp1;
    logic [1:0] pick;
    logic       pick_wr, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign req0 = '{inport0.awvalid, inport0.awaddr, inport0.wvalid, inport0.wdata, inport0.wstrb,
                    inport0.bready, inport0.arvalid, inport0.araddr, inport0.rready};
    assign req1 = '{inport1.awvalid, inport1.awaddr, inport1.wvalid, inport1.wdata, inport1.wstrb,
                    inport1.bready, inport1.arvalid, inport1.araddr, inport1.rready};
    assign rsp_slv = '{outport.awready, outport.wready, outport.bvalid, outport.bresp,
                       outport.arready, outport.rvalid, outport.rdata, outport.rresp};

    assign req_sel = grant_q[1] ? req1 : req0;

    axil_rr_pick2 u_pick (
        .req_i        ({req1.awvalid | req1.arvalid, req0.awvalid | req0.arvalid}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );
    assign pick_wr = pick[1] ? req1.awvalid : req0.awvalid;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q, is_wr_q, mst_done_q, slv_done_q;
    logic             expire, mst_ok, slv_ok;

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mst_ok = mst_done_q | (is_wr_q ? req_sel.bready : req_sel.rready);
    assign slv_ok = slv_done_q | expire | (is_wr_q ? rsp_slv.bvalid : rsp_slv.rvalid);
`endif

    // NOTE: every field gets a default before the case, so no path leaves a latch.
    always_comb begin
        req_out         = req_sel;
        req_out.awvalid = 1'b0;
        req_out.wvalid  = 1'b0;
        req_out.bready  = 1'b0;
        req_out.arvalid = 1'b0;
        req_out.rready  = 1'b0;
        rsp_m           = rsp_slv;
        rsp_m.awready   = 1'b0;
        rsp_m.wready    = 1'b0;
        rsp_m.bvalid    = 1'b0;
        rsp_m.arready   = 1'b0;
        rsp_m.rvalid    = 1'b0;
        case (state_q)
            ST_WR: begin
                // A channel that already handshook is masked until the other catches up.
                req_out.awvalid = req_sel.awvalid && !aw_done_q;
                req_out.wvalid  = req_sel.wvalid  && !w_done_q;
                rsp_m.awready   = rsp_slv.awready && !aw_done_q;
                rsp_m.wready    = rsp_slv.wready  && !w_done_q;
            end
            ST_WR_RESP: begin
                req_out.bready = req_sel.bready;
                rsp_m.bvalid   = rsp_slv.bvalid;
            end
            ST_RD: begin
                req_out.arvalid = req_sel.arvalid;
                rsp_m.arready   = rsp_slv.arready;
            end
            ST_RD_RESP: begin
                req_out.rready = req_sel.rready;
                rsp_m.rvalid   = rsp_slv.rvalid;
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                // Swallow any late slave response while the master gets SLVERR.
                req_out.bready = 1'b1;
                req_out.rready = 1'b1;
                if (is_wr_q) begin
                    rsp_m.bvalid = !mst_done_q;
                    rsp_m.bresp  = RESP_SLVERR;
                end else begin
                    rsp_m.rvalid = !mst_done_q;
                    rsp_m.rresp  = RESP_SLVERR;
                    rsp_m.rdata  = '0;
                end
            end
`endif
            default: ;
        endcase
    end

    assign aw_hs = req_out.awvalid && rsp_slv.awready;
    assign w_hs  = req_out.wvalid  && rsp_slv.wready;
    assign b_hs  = rsp_slv.bvalid  && req_sel.bready;
    assign ar_hs = req_out.arvalid && rsp_slv.arready;
    assign r_hs  = rsp_slv.rvalid  && req_sel.rready;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            is_wr_q      <= 1'b0;
            mst_done_q   <= 1'b0;
            slv_done_q   <= 1'b0;
`endif
        end else begin
`ifdef AXIL_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                    if (|pick) begin
                        grant_q <= pick;
                        state_q <= pick_wr ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q | w_hs;
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_q <= ST_WR_RESP;
                end
                ST_RD: if (ar_hs) state_q <= ST_RD_RESP;
                ST_WR_RESP, ST_RD_RESP: begin
                    if ((state_q == ST_WR_RESP) ? b_hs : r_hs) begin
                        state_q      <= ST_IDLE;
                        grant_q      <= '0;
                        last_grant_q <= grant_q[1];
                    end
`ifdef AXIL_ARB_TIMEOUT_EN
                    else if (expire) begin
                        state_q    <= ST_FLUSH;
                        timeout_q  <= 1'b1;
                        cnt_q      <= '0;
                        is_wr_q    <= (state_q == ST_WR_RESP);
                        mst_done_q <= 1'b0;
                        slv_done_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                ST_FLUSH: begin
                    if (mst_ok && slv_ok) begin
                        state_q      <= ST_IDLE;
                        grant_q      <= '0;
                        last_grant_q <= grant_q[1];
                    end else begin
                        mst_done_q <= mst_ok;
                        slv_done_q <= slv_ok;
                        if (!expire) cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp0 = grant_q[0] ? rsp_m : '0;
    assign rsp1 = grant_q[1] ? rsp_m : '0;

    assign {inport0.awready, inport0.wready, inport0.bvalid, inport0.bresp,
            inport0.arready, inport0.rvalid, inport0.rdata, inport0.rresp} = rsp0;
    assign {inport1.awready, inport1.wready, inport1.bvalid, inport1.bresp,
            inport1.arready, inport1.rvalid, inport1.rdata, inport1.rresp} = rsp1;
    assign {outport.awvalid, outport.awaddr, outport.wvalid, outport.wdata, outport.wstrb,
            outport.bready, outport.arvalid, outport.araddr, outport.rready} = req_out;

    assign grant_o = grant_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_arb2.sv
// Directed bench for axi4lite_arb2; the watchdog scenario runs when
// AXIL_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
`timescale 1ns/1ps
module tb_axi4lite_arb2;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout;
    int         checks = 0;
    int         errors = 0;
    int         aw_cnt = 0;
    int         w_cnt = 0;

    axil_if m0();
    axil_if m1();
    axil_if s();

    axi4lite_arb2 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .inport0   (m0),
        .inport1   (m1),
        .outport   (s),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s.awvalid && s.awready) aw_cnt <= aw_cnt + 1;
        if (s.wvalid && s.wready)   w_cnt  <= w_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_bus();
        {m0.awvalid, m0.awaddr, m0.wvalid, m0.wdata, m0.wstrb, m0.bready, m0.arvalid, m0.araddr, m0.rready} = '0;
        {m1.awvalid, m1.awaddr, m1.wvalid, m1.wdata, m1.wstrb, m1.bready, m1.arvalid, m1.araddr, m1.rready} = '0;
        {s.awready, s.wready, s.bvalid, s.bresp, s.arready, s.rvalid, s.rdata, s.rresp} = '0;
    endtask

    task automatic do_reset();
        init_bus();
        rst_n = 1'b0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    // Completes a granted read on the slave side and drops the winner's arvalid.
    task automatic serve_rd();
        s.arready = 1'b1;
        step();
        if (grant[0]) m0.arvalid = 1'b0;
        else          m1.arvalid = 1'b0;
        s.arready = 1'b0;
        s.rvalid  = 1'b1;
        s.rdata   = 32'h0BAD_F00D;
        step();
        s.rvalid  = 1'b0;
    endtask

    task automatic test_reset();
        init_bus();
        rst_n = 1'b0;
        m0.arvalid = 1'b1;
        #12;
        checks++;
        if (grant !== 2'b00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant: got grant=%b timeout=%b, need 00/0", grant, timeout);
        end
        checks++;
        if ({s.awvalid, s.wvalid, s.bready, s.arvalid, s.rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_out_hs: got %b, need 00000",
                     {s.awvalid, s.wvalid, s.bready, s.arvalid, s.rready});
        end
        checks++;
        if ({m0.awready, m0.wready, m0.bvalid, m0.arready, m0.rvalid,
             m1.awready, m1.wready, m1.bvalid, m1.arready, m1.rvalid} !== 10'b0) begin
            errors++;
            $display("FAIL reset_in_hs: got %b, need all 0",
                     {m0.awready, m0.wready, m0.bvalid, m0.arready, m0.rvalid,
                      m1.awready, m1.wready, m1.bvalid, m1.arready, m1.rvalid});
        end
        m0.arvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        m0.awvalid = 1'b1; m0.awaddr = 32'h9200_0000;
        m0.wvalid  = 1'b1; m0.wdata  = 32'hA5A5_A5A5; m0.wstrb = 4'hF;
        m0.bready  = 1'b1;
        #1;
        checks++;
        if (grant !== 2'b00 || s.awvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_not_early: got grant=%b awvalid=%b, need 00/0", grant, s.awvalid);
        end
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL wr_grant: got %b, need 01", grant);
        end
        checks++;
        if ({s.awvalid, s.awaddr, s.wvalid, s.wdata, s.wstrb} !== {1'b1, 32'h9200_0000, 1'b1, 32'hA5A5_A5A5, 4'hF}) begin
            errors++;
            $display("FAIL wr_fwd: got aw=%b/%h w=%b/%h/%h, need 1/92000000 1/a5a5a5a5/f",
                     s.awvalid, s.awaddr, s.wvalid, s.wdata, s.wstrb);
        end
        s.awready = 1'b1; s.wready = 1'b1;
        #1;
        checks++;
        if ({m0.awready, m0.wready, m1.awready, m1.wready} !== 4'b1100) begin
            errors++;
            $display("FAIL wr_readies: got %b, need 1100", {m0.awready, m0.wready, m1.awready, m1.wready});
        end
        step();
        m0.awvalid = 1'b0; m0.wvalid = 1'b0;
        s.awready = 1'b0; s.wready = 1'b0;
        s.bvalid = 1'b1; s.bresp = 2'b00;
        #1;
        checks++;
        if ({m0.bvalid, m0.bresp, s.bready, m1.bvalid} !== 5'b10010) begin
            errors++;
            $display("FAIL wr_bresp: got %b, need 10010", {m0.bvalid, m0.bresp, s.bready, m1.bvalid});
        end
        step();
        s.bvalid = 1'b0; m0.bready = 1'b0;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL wr_grant_drop: got %b, need 00", grant);
        end
        step();
    endtask

    task automatic test_rr_reads();
        do_reset();
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_1000; m0.rready = 1'b1;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_2000; m1.rready = 1'b1;
        step();
        checks++;
        if (grant !== 2'b01 || s.araddr !== 32'h0000_1000) begin
            errors++;
            $display("FAIL rr_first: got grant=%b araddr=%h, need 01/00001000", grant, s.araddr);
        end
        s.arready = 1'b1;
        #1;
        checks++;
        if ({m0.arready, m1.arready} !== 2'b10) begin
            errors++;
            $display("FAIL rr_arready: got %b, need 10", {m0.arready, m1.arready});
        end
        step();
        m0.arvalid = 1'b0; s.arready = 1'b0;
        s.rvalid = 1'b1; s.rdata = 32'hCAFE_0001; s.rresp = 2'b00;
        #1;
        checks++;
        if ({m0.rvalid, m0.rdata, m0.rresp, m1.rvalid} !== {1'b1, 32'hCAFE_0001, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL rr_rdata0: got %b/%h/%b other=%b, need 1/cafe0001/00 0",
                     m0.rvalid, m0.rdata, m0.rresp, m1.rvalid);
        end
        step();
        s.rvalid = 1'b0;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle_gap: got %b, need 00", grant);
        end
        step();
        checks++;
        if (grant !== 2'b10 || s.araddr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL rr_second: got grant=%b araddr=%h, need 10/00002000", grant, s.araddr);
        end
        s.arready = 1'b1;
        step();
        m1.arvalid = 1'b0; s.arready = 1'b0;
        s.rvalid = 1'b1; s.rdata = 32'hBEEF_0002;
        #1;
        checks++;
        if ({m1.rvalid, m1.rdata, m0.rvalid} !== {1'b1, 32'hBEEF_0002, 1'b0}) begin
            errors++;
            $display("FAIL rr_rdata1: got %b/%h other=%b, need 1/beef0002 0", m1.rvalid, m1.rdata, m0.rvalid);
        end
        step();
        s.rvalid = 1'b0;
        m0.arvalid = 1'b1; m1.arvalid = 1'b1;
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL rr_third: got %b, need 01", grant);
        end
        serve_rd();
        step();
        serve_rd();
        m0.rready = 1'b0; m1.rready = 1'b0;
        step();
    endtask

    task automatic test_w_before_aw();
        int aw0, w0;
        m0.awvalid = 1'b1; m0.awaddr = 32'h0000_0010;
        m0.wvalid  = 1'b1; m0.wdata  = 32'h0000_1234; m0.wstrb = 4'h3;
        m0.bready  = 1'b1;
        step();
        aw0 = aw_cnt; w0 = w_cnt;
        s.wready = 1'b1;
        #1;
        checks++;
        if ({m0.wready, m0.awready} !== 2'b10) begin
            errors++;
            $display("FAIL wfirst_ready: got %b, need 10", {m0.wready, m0.awready});
        end
        step();
        m0.wvalid = 1'b0; s.wready = 1'b0;
        step();
        step();
        checks++;
        if ({s.awvalid, s.wvalid, s.bready} !== 3'b100) begin
            errors++;
            $display("FAIL wfirst_wait: got %b, need 100", {s.awvalid, s.wvalid, s.bready});
        end
        s.awready = 1'b1;
        step();
        m0.awvalid = 1'b0; s.awready = 1'b0;
        #1;
        checks++;
        if (s.bready !== 1'b1 || (aw_cnt - aw0) !== 1 || (w_cnt - w0) !== 1) begin
            errors++;
            $display("FAIL wfirst_resp: got bready=%b aw=%0d w=%0d, need 1/1/1",
                     s.bready, aw_cnt - aw0, w_cnt - w0);
        end
        s.bvalid = 1'b1;
        step();
        s.bvalid = 1'b0; m0.bready = 1'b0;
        step();
    endtask

    task automatic test_port1_aw_ar();
        m1.awvalid = 1'b1; m1.awaddr = 32'h0000_3000;
        m1.wvalid  = 1'b1; m1.wdata  = 32'h5555_AAAA; m1.wstrb = 4'b0101;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_4000;
        m1.bready  = 1'b1; m1.rready = 1'b1;
        step();
        checks++;
        if ({grant, s.awvalid, s.arvalid, s.wstrb} !== {2'b10, 1'b1, 1'b0, 4'b0101}) begin
            errors++;
            $display("FAIL p1_write_first: got grant=%b aw=%b ar=%b strb=%b, need 10/1/0/0101",
                     grant, s.awvalid, s.arvalid, s.wstrb);
        end
        s.awready = 1'b1; s.wready = 1'b1;
        step();
        m1.awvalid = 1'b0; m1.wvalid = 1'b0;
        s.awready = 1'b0; s.wready = 1'b0;
        s.bvalid = 1'b1; s.bresp = 2'b10;
        #1;
        checks++;
        if ({m1.bvalid, m1.bresp} !== 3'b110) begin
            errors++;
            $display("FAIL p1_bresp: got %b/%b, need 1/10", m1.bvalid, m1.bresp);
        end
        step();
        s.bvalid = 1'b0; s.bresp = 2'b00;
        step();
        checks++;
        if ({grant, s.arvalid, s.araddr} !== {2'b10, 1'b1, 32'h0000_4000}) begin
            errors++;
            $display("FAIL p1_read_next: got grant=%b ar=%b addr=%h, need 10/1/00004000",
                     grant, s.arvalid, s.araddr);
        end
        serve_rd();
        m1.bready = 1'b0; m1.rready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_5000; m0.rready = 1'b0;
        step();
        s.arready = 1'b1;
        step();
        m0.arvalid = 1'b0; s.arready = 1'b0;
        s.rvalid = 1'b1; s.rdata = 32'h7777_7777;
        #1;
        checks++;
        if (m0.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got rvalid=%b, need 1", m0.rvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, m0.rvalid, s.rready, s.arvalid} !== 5'b0) begin
            errors++;
            $display("FAIL mid_async: got %b, need 00000", {grant, m0.rvalid, s.rready, s.arvalid});
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if ({grant, m0.rvalid} !== 3'b000) begin
            errors++;
            $display("FAIL mid_no_resp: got grant=%b rvalid=%b, need 00/0", grant, m0.rvalid);
        end
        s.rvalid = 1'b0;
        m1.arvalid = 1'b1; m1.araddr = 32'h0000_6000; m1.rready = 1'b1;
        step();
        checks++;
        if ({grant, s.arvalid, s.araddr} !== {2'b10, 1'b1, 32'h0000_6000}) begin
            errors++;
            $display("FAIL mid_regrant: got grant=%b ar=%b addr=%h, need 10/1/00006000",
                     grant, s.arvalid, s.araddr);
        end
        serve_rd();
        m1.rready = 1'b0;
        step();
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen;
        m0.arvalid = 1'b1; m0.araddr = 32'h0000_7000; m0.rready = 1'b1;
        step();
        s.arready = 1'b1;
        step();
        m0.arvalid = 1'b0; s.arready = 1'b0;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n++;
            seen = timeout;
        end
        checks++;
        if (!seen || n !== TO) begin
            errors++;
            $display("FAIL to_pulse_at: got seen=%b cycles=%0d, need 1/%0d", seen, n, TO);
        end
        checks++;
        if ({m0.rvalid, m0.rresp, m0.rdata, s.rready} !== {1'b1, 2'b10, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL to_slverr: got rvalid=%b rresp=%b rdata=%h rready=%b, need 1/10/0/1",
                     m0.rvalid, m0.rresp, m0.rdata, s.rready);
        end
        step();
        checks++;
        if ({timeout, grant, m0.rvalid} !== {1'b0, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL to_flush: got timeout=%b grant=%b rvalid=%b, need 0/01/0", timeout, grant, m0.rvalid);
        end
        s.rvalid = 1'b1; s.rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({m0.rvalid, s.rready} !== 2'b01) begin
            errors++;
            $display("FAIL to_swallow: got rvalid=%b rready=%b, need 0/1", m0.rvalid, s.rready);
        end
        step();
        s.rvalid = 1'b0;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL to_exit: got %b, need 00", grant);
        end
        m0.rready = 1'b0;
        step();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_rr_reads();
        test_w_before_aw();
        test_port1_aw_ar();
        test_reset_mid();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
